// File: rtl/result_serializer.sv
// result_serializer: streams a parallel result word out one bit at a time on
// ser_out, framed by ser_frame, with an optional trailing even-parity bit.
module result_serializer #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             ser_out_d;
  logic             ser_frame_d;
  logic             done_d;

  // in_ready only decodes the state register
  assign in_ready = (state_q == IDLE);

  // Next-state, datapath and next-output logic; ser_out/ser_frame/done are
  // precomputed here so they leave the block straight from flops.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          par_d   = ^in_data;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (ser_en) begin
          if (MSB_FIRST) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = PARITY_EN ? PARITY : IDLE;
          end
        end
      end
      PARITY: begin
        if (ser_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ser_frame_d = (state_d != IDLE);
    done_d      = (state_q != IDLE) && (state_d == IDLE);

    case (state_d)
      DATA:    ser_out_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
      PARITY:  ser_out_d = par_d;
      default: ser_out_d = 1'b0;
    endcase
  end

  // State, datapath and output registers; reset drops any word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      par_q     <= 1'b0;
      ser_out   <= 1'b0;
      ser_frame <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      ser_out   <= ser_out_d;
      ser_frame <= ser_frame_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: MSB-first with parity (dut) and
// LSB-first without parity (dut2).
module tb_result_serializer;

  logic        clk;
  logic        rst_n;
  logic        ser_en;

  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        ser_out;
  logic        ser_frame;
  logic        done;

  logic        in_valid2;
  logic [31:0] in_data2;
  logic        in_ready2;
  logic        ser_out2;
  logic        ser_frame2;
  logic        done2;

  int checks;
  int fails;

  result_serializer #(.WIDTH(32), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .ser_en(ser_en), .ser_out(ser_out),
    .ser_frame(ser_frame), .done(done)
  );

  result_serializer #(.WIDTH(32), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .ser_en(ser_en), .ser_out(ser_out2),
    .ser_frame(ser_frame2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset ser_out", ser_out, 1'b0);
    chk("reset ser_frame", ser_frame, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset in_ready2", in_ready2, 1'b1);
    chk("reset ser_frame2", ser_frame2, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Send one word through dut with ser_en high; checks every cycle of the frame
  task automatic test_send(input logic [31:0] w);
    logic acc;
    acc = 1'b0;
    chk("send idle in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      chk("send data bit", ser_out, w[32-i]);
      chk("send frame", ser_frame, 1'b1);
      chk("send done low", done, 1'b0);
      acc = acc ^ ser_out;
      tick();
    end
    chk("send parity bit", ser_out, ^w);
    chk("send parity frame", ser_frame, 1'b1);
    acc = acc ^ ser_out;
    chk("send even parity", acc, 1'b0);
    tick();
    chk("send done pulse", done, 1'b1);
    chk("send end in_ready", in_ready, 1'b1);
    chk("send end frame", ser_frame, 1'b0);
    chk("send end ser_out", ser_out, 1'b0);
    tick();
    chk("send done cleared", done, 1'b0);
  endtask

  task automatic test_gated();
    logic [31:0] w;
    logic [32:0] bits;
    int          b;
    w    = 32'hA5A5A5A5;
    bits = {w, 1'b0};
    in_valid = 1'b1;
    in_data  = w;
    ser_en   = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 99; c++) begin
      ser_en = (c % 3 == 0);
      b = (c - 1) / 3;
      chk("gated bit", ser_out, bits[32-b]);
      chk("gated frame", ser_frame, 1'b1);
      tick();
    end
    ser_en = 1'b1;
    chk("gated end frame", ser_frame, 1'b0);
    chk("gated done", done, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] cur;
    logic [31:0] word;
    int          p;
    tick();
    for (int t = 0; t < 3 * 34; t++) begin
      cur      = 32'(t) * 32'h01010101 ^ 32'hDEADBEEF;
      in_valid = 1'b1;
      in_data  = cur;
      p = t % 34;
      if (p == 0) begin
        word = cur;
        chk("b2b gap frame", ser_frame, 1'b0);
        chk("b2b gap in_ready", in_ready, 1'b1);
        chk("b2b gap done", done, (t != 0));
      end else if (p <= 32) begin
        chk("b2b data bit", ser_out, word[32-p]);
        chk("b2b frame", ser_frame, 1'b1);
        chk("b2b busy in_ready", in_ready, 1'b0);
      end else begin
        chk("b2b parity", ser_out, ^word);
        chk("b2b parity frame", ser_frame, 1'b1);
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("b2b final idle frame", ser_frame, 1'b0);
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    in_data  = 32'hFFFFFFFF;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("rst mid frame", ser_frame, 1'b1);
    chk("rst mid bit", ser_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async frame", ser_frame, 1'b0);
    chk("rst async ser_out", ser_out, 1'b0);
    chk("rst async done", done, 1'b0);
    chk("rst async in_ready", in_ready, 1'b1);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    chk("rst no resume", ser_frame, 1'b0);
    test_send(32'h12345678);
  endtask

  task automatic test_lsb_no_parity();
    logic [31:0] w;
    w = 32'h00000001;
    in_valid2 = 1'b1;
    in_data2  = w;
    tick();
    in_valid2 = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      chk("lsb bit", ser_out2, w[i-1]);
      chk("lsb frame", ser_frame2, 1'b1);
      chk("lsb done low", done2, 1'b0);
      tick();
    end
    chk("lsb done", done2, 1'b1);
    chk("lsb no parity frame", ser_frame2, 1'b0);
    chk("lsb in_ready", in_ready2, 1'b1);
    tick();
    chk("lsb done cleared", done2, 1'b0);
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    ser_en    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_valid2 = 1'b0;
    in_data2  = '0;
    test_reset();
    test_send(32'h80000001);
    test_send(32'h00000007);
    test_send(32'hFFFFFFFF);
    test_gated();
    test_back_to_back();
    test_async_reset();
    test_lsb_no_parity();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
# result_serializer

Parallel-to-serial transmitter that sends a WIDTH-bit result word one bit at a time on a single output pin, with a frame flag and an optional trailing even-parity bit. It is the transmit counterpart of the wrapper's serial operand shift-in path: the module under exploration produces a parallel result, and this block streams it off-chip over one pin instead of using a byte-muxed parallel bus. It sits between the result bus and a `uo_out` bit inside a `tt_um_*` top.

## Interface

Parameters:
- `WIDTH`, 32, data bits per word (≥2)
- `MSB_FIRST`, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first
- `PARITY_EN`, 1, 1 = append one even-parity bit after the data bits; 0 = no parity bit

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `in_data` is offered
- `in_ready`  out  1  block is IDLE and will accept a word this cycle
- `in_data`  in  WIDTH  parallel result word
- `ser_en`  in  1  bit-advance enable; tie high for one bit per clock, or drive from a divider or pin for slower rates
- `ser_out`  out  1  serial data
- `ser_frame`  out  1  high while a data or parity bit is on `ser_out`
- `done`  out  1  one-cycle pulse after the last bit of a word

## Operation

- States: IDLE, DATA, PARITY.
- Registers: shift register (WIDTH), bit counter ($clog2(WIDTH) bits), parity bit, state, `done`.
- IDLE:
  - `in_ready`=1, `ser_frame`=0, `ser_out`=0.
  - `in_valid`=1 at a clock edge: load `in_data` into the shift register, store parity = XOR of all `in_data` bits, clear bit counter, go to DATA.
- DATA:
  - `ser_frame`=1.
  - `ser_out` = shift-register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0).
  - Each edge with `ser_en`=1: shift by one toward the output end (zero fill), bit counter +1.
  - Edge with `ser_en`=1 and counter = WIDTH-1: go to PARITY if PARITY_EN=1, else IDLE.
  - Edges with `ser_en`=0 change nothing.
- PARITY:
  - `ser_frame`=1, `ser_out` = stored parity bit.
  - Edge with `ser_en`=1: go to IDLE.
- `done`: registered; high for exactly the first cycle after the final bit leaves (the first IDLE cycle), low otherwise.
- `in_ready` is combinational from state (= state==IDLE). `in_valid` outside IDLE is ignored; the word in flight is never corrupted.
- `ser_en` is ignored in IDLE.
- Even parity: data bits plus parity bit contain an even number of ones.
- Reset (asynchronous, any state, including mid-word):
  - immediately: state=IDLE, shift register=0, counter=0, parity=0, `done`=0;
  - outputs `in_ready`=1, `ser_out`=0, `ser_frame`=0.
  - The partial word is discarded and is not resumed after reset.

## Timing

- Acceptance at edge 0: first bit on `ser_out`, with `ser_frame`=1, in cycle 1, immediately after the edge.
- With `ser_en` tied high and PARITY_EN=1:
  - data bits in cycles 1..WIDTH, parity in cycle WIDTH+1;
  - `done`=1 and `in_ready`=1 in cycle WIDTH+2;
  - earliest next acceptance at edge WIDTH+2, so the word period is WIDTH+2 cycles (34 for WIDTH=32).
  - With PARITY_EN=0: period is WIDTH+1.
- With `ser_en` gated, each bit is held until the edge on which `ser_en`=1.
- Between frames there is at least one cycle with `ser_frame`=0, which marks the word boundary.
- All outputs are glitch-free from registers, except `in_ready`, which decodes state only.

## Test plan

- WIDTH=32, MSB_FIRST=1, `ser_en`=1; send 0x80000001 → `ser_out` in cycles 1..32 is 1, then 0 ×30, then 1; parity 0 in cycle 33; `done`=1 only in cycle 34; `ser_frame` high in cycles 1..33.
- Send 0x00000007 → parity bit 1; send 0xFFFFFFFF → parity bit 0. Check: XOR of all 33 frame bits is 0 in every case.
- `ser_en` pulsed every 3rd cycle, word 0xA5A5A5A5 → each bit held exactly 3 cycles; bit sequence 1010 0101…; frame length 99 cycles.
- `in_valid`=1 continuously with changing `in_data` → only the values present on IDLE cycles are sent; back-to-back frames are separated by exactly one `ser_frame`=0 cycle; no bit corruption.
- Assert `rst_n`=0 asynchronously during data bit 10 → `ser_frame`, `ser_out` and `done` drop to 0 and `in_ready` rises before the next clock edge; after release, 0x12345678 is sent complete and correct.
- MSB_FIRST=0, PARITY_EN=0, send 0x00000001 → first bit 1, then 31 zeros, no parity bit; `done` in cycle 33.
